// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared types and constants for the commit-boundary trap
// sequencer.
//   - exception flag bit indices; bit index is also the priority, 0 highest
//   - trap cause enum, ESTAT ecode/esubcode constants
//   - bad-address source select and sequencer state enums
package trap_ctrl_pkg;

    localparam int EXCP_W = 15;

    // Exception flag bit positions inside commit_excp.
    localparam int EXCP_ADEF   = 0;
    localparam int EXCP_TLBR_F = 1;
    localparam int EXCP_PIF    = 2;
    localparam int EXCP_PPI_F  = 3;
    localparam int EXCP_IPE    = 4;
    localparam int EXCP_INE    = 5;
    localparam int EXCP_SYS    = 6;
    localparam int EXCP_BRK    = 7;
    localparam int EXCP_ALE    = 8;
    localparam int EXCP_ADEM   = 9;
    localparam int EXCP_TLBR_M = 10;
    localparam int EXCP_PIL    = 11;
    localparam int EXCP_PIS    = 12;
    localparam int EXCP_PME    = 13;
    localparam int EXCP_PPI_M  = 14;

    // ESTAT.Ecode values.
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    // ESTAT.EsubCode values (only ADE distinguishes fetch vs memory).
    localparam logic [8:0] ESUB_NONE = 9'd0;
    localparam logic [8:0] ESUB_ADEF = 9'd0;
    localparam logic [8:0] ESUB_ADEM = 9'd1;

    // CAUSE_NONE is the idle value so the cause output reads 0 outside TRAP.
    typedef enum logic [4:0] {
        CAUSE_NONE   = 5'd0,
        CAUSE_INT    = 5'd1,
        CAUSE_ADEF   = 5'd2,
        CAUSE_TLBR_F = 5'd3,
        CAUSE_PIF    = 5'd4,
        CAUSE_PPI_F  = 5'd5,
        CAUSE_IPE    = 5'd6,
        CAUSE_INE    = 5'd7,
        CAUSE_SYS    = 5'd8,
        CAUSE_BRK    = 5'd9,
        CAUSE_ALE    = 5'd10,
        CAUSE_ADEM   = 5'd11,
        CAUSE_TLBR_M = 5'd12,
        CAUSE_PIL    = 5'd13,
        CAUSE_PIS    = 5'd14,
        CAUSE_PME    = 5'd15,
        CAUSE_PPI_M  = 5'd16
    } trap_cause_t;

    // Source of the value written to BADV.
    typedef enum logic [1:0] {
        ADDR_ZERO = 2'd0,
        ADDR_PC   = 2'd1,
        ADDR_MEM  = 2'd2
    } addr_sel_t;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_TRAP   = 3'd1,
        ST_ERET   = 3'd2,
        ST_IDLE   = 3'd3,
        ST_RESUME = 3'd4
    } trap_state_t;

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: commit-stage handshake bundle.
//   commit_valid / commit_ready : one-instruction transfer, valid & ready
//   commit_pc, commit_excp, commit_mem_addr, commit_ertn, commit_idle :
//       payload of the presented instruction
// master = commit stage, slave = trap sequencer.
interface trap_ctrl_if;
    import trap_ctrl_pkg::*;

    logic              commit_valid;
    logic              commit_ready;
    logic [31:0]       commit_pc;
    logic [EXCP_W-1:0] commit_excp;
    logic [31:0]       commit_mem_addr;
    logic              commit_ertn;
    logic              commit_idle;

    modport master (
        output commit_valid, commit_pc, commit_excp, commit_mem_addr,
               commit_ertn, commit_idle,
        input  commit_ready
    );

    modport slave (
        input  commit_valid, commit_pc, commit_excp, commit_mem_addr,
               commit_ertn, commit_idle,
        output commit_ready
    );

endinterface

// File: rtl/trap_ctrl_excp_prio_enc.sv
// excp_prio_enc: combinational priority encoder for trap events.
//   excp_i      : 15 exception flags, bit 0 highest priority
//   int_take_i  : enabled interrupt pending (beats every exception)
//   valid_o     : some event selected
//   cause_o, ecode_o, esubcode_o : decoded cause
//   addr_sel_o  : BADV source for the selected event
module excp_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic [EXCP_W-1:0] excp_i,
    input  logic              int_take_i,
    output logic              valid_o,
    output trap_cause_t       cause_o,
    output logic [5:0]        ecode_o,
    output logic [8:0]        esubcode_o,
    output addr_sel_t         addr_sel_o
);

    // One-hot of the lowest set flag.
    logic [EXCP_W-1:0] first_hot;

    genvar gi;
    generate
        for (gi = 0; gi < EXCP_W; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign first_hot[gi] = excp_i[gi];
            end else begin : g_upper
                assign first_hot[gi] = excp_i[gi] & ~(|excp_i[gi-1:0]);
            end
        end
    endgenerate

    logic [3:0] idx;

    always_comb begin
        idx = 4'd0;
        for (int i = 0; i < EXCP_W; i++) begin
            if (first_hot[i]) idx = idx | i[3:0];
        end
    end

    always_comb begin
        valid_o    = 1'b0;
        cause_o    = CAUSE_NONE;
        ecode_o    = 6'd0;
        esubcode_o = ESUB_NONE;
        addr_sel_o = ADDR_ZERO;
        if (int_take_i) begin
            valid_o = 1'b1;
            cause_o = CAUSE_INT;
            ecode_o = ECODE_INT;
        end else if (|excp_i) begin
            valid_o = 1'b1;
            case (idx)
                4'd0:  begin cause_o = CAUSE_ADEF;   ecode_o = ECODE_ADE;  esubcode_o = ESUB_ADEF; addr_sel_o = ADDR_PC;  end
                4'd1:  begin cause_o = CAUSE_TLBR_F; ecode_o = ECODE_TLBR; addr_sel_o = ADDR_PC;  end
                4'd2:  begin cause_o = CAUSE_PIF;    ecode_o = ECODE_PIF;  addr_sel_o = ADDR_PC;  end
                4'd3:  begin cause_o = CAUSE_PPI_F;  ecode_o = ECODE_PPI;  addr_sel_o = ADDR_PC;  end
                4'd4:  begin cause_o = CAUSE_IPE;    ecode_o = ECODE_IPE;  end
                4'd5:  begin cause_o = CAUSE_INE;    ecode_o = ECODE_INE;  end
                4'd6:  begin cause_o = CAUSE_SYS;    ecode_o = ECODE_SYS;  end
                4'd7:  begin cause_o = CAUSE_BRK;    ecode_o = ECODE_BRK;  end
                4'd8:  begin cause_o = CAUSE_ALE;    ecode_o = ECODE_ALE;  addr_sel_o = ADDR_MEM; end
                4'd9:  begin cause_o = CAUSE_ADEM;   ecode_o = ECODE_ADE;  esubcode_o = ESUB_ADEM; addr_sel_o = ADDR_MEM; end
                4'd10: begin cause_o = CAUSE_TLBR_M; ecode_o = ECODE_TLBR; addr_sel_o = ADDR_MEM; end
                4'd11: begin cause_o = CAUSE_PIL;    ecode_o = ECODE_PIL;  addr_sel_o = ADDR_MEM; end
                4'd12: begin cause_o = CAUSE_PIS;    ecode_o = ECODE_PIS;  addr_sel_o = ADDR_MEM; end
                4'd13: begin cause_o = CAUSE_PME;    ecode_o = ECODE_PME;  addr_sel_o = ADDR_MEM; end
                default: begin cause_o = CAUSE_PPI_M; ecode_o = ECODE_PPI; addr_sel_o = ADDR_MEM; end
            endcase
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-boundary trap sequencer.
//   clk, rst            : clock, synchronous active-high reset
//   commit (slave)      : commit-stage handshake and instruction payload
//   crmd_ie, ecfg_lie, estat_is : interrupt enable / status from CSRs
//   eentry_va, tlbrentry_pa, era_pc : redirect targets
//   is_exception, exception_cause, ecode, esubcode, exception_pc,
//   exception_addr      : one-cycle CSR exception update
//   is_ertn             : one-cycle CSR restore pulse
//   flush, redirect_valid, redirect_pc : front-end flush/redirect
//   idle_stall          : pipeline frozen waiting for an interrupt
// Every output is a register loaded on the accept edge, so each event shows
// up exactly one cycle after the commit that caused it.
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    trap_ctrl_if.slave   commit,
    input  logic         crmd_ie,
    input  logic [11:0]  ecfg_lie,
    input  logic [11:0]  estat_is,
    input  logic [31:0]  eentry_va,
    input  logic [31:0]  tlbrentry_pa,
    input  logic [31:0]  era_pc,
    output logic         is_exception,
    output trap_cause_t  exception_cause,
    output logic [5:0]   ecode,
    output logic [8:0]   esubcode,
    output logic [31:0]  exception_pc,
    output logic [31:0]  exception_addr,
    output logic         is_ertn,
    output logic         flush,
    output logic         redirect_valid,
    output logic [31:0]  redirect_pc,
    output logic         idle_stall
);

    logic int_pend;
    logic int_take;
    logic accept;

    assign int_pend = |(ecfg_lie & estat_is);
    assign int_take = int_pend & crmd_ie;

    logic        enc_valid;
    trap_cause_t enc_cause;
    logic [5:0]  enc_ecode;
    logic [8:0]  enc_esub;
    addr_sel_t   enc_sel;

    excp_prio_enc u_prio (
        .excp_i     (commit.commit_excp),
        .int_take_i (int_take),
        .valid_o    (enc_valid),
        .cause_o    (enc_cause),
        .ecode_o    (enc_ecode),
        .esubcode_o (enc_esub),
        .addr_sel_o (enc_sel)
    );

    trap_state_t state_q, state_d;
    logic        ready_q, ready_d;
    logic        is_exc_q, is_exc_d;
    trap_cause_t cause_q, cause_d;
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esub_q, esub_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] eaddr_q, eaddr_d;
    logic        is_ertn_q, is_ertn_d;
    logic        flush_q, flush_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rpc_q, rpc_d;
    logic        stall_q, stall_d;
    logic [31:0] idle_pc4_q, idle_pc4_d;

    // commit_ready is a register that is 1 exactly in RUN.
    assign accept = commit.commit_valid & ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            ready_q    <= 1'b1;
            is_exc_q   <= 1'b0;
            cause_q    <= CAUSE_NONE;
            ecode_q    <= 6'd0;
            esub_q     <= 9'd0;
            epc_q      <= 32'd0;
            eaddr_q    <= 32'd0;
            is_ertn_q  <= 1'b0;
            flush_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rpc_q      <= 32'd0;
            stall_q    <= 1'b0;
            idle_pc4_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            is_exc_q   <= is_exc_d;
            cause_q    <= cause_d;
            ecode_q    <= ecode_d;
            esub_q     <= esub_d;
            epc_q      <= epc_d;
            eaddr_q    <= eaddr_d;
            is_ertn_q  <= is_ertn_d;
            flush_q    <= flush_d;
            rvalid_q   <= rvalid_d;
            rpc_q      <= rpc_d;
            stall_q    <= stall_d;
            idle_pc4_q <= idle_pc4_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ready_d    = 1'b0;
        is_exc_d   = 1'b0;
        cause_d    = CAUSE_NONE;
        ecode_d    = 6'd0;
        esub_d     = 9'd0;
        epc_d      = 32'd0;
        eaddr_d    = 32'd0;
        is_ertn_d  = 1'b0;
        flush_d    = 1'b0;
        rvalid_d   = 1'b0;
        rpc_d      = 32'd0;
        stall_d    = 1'b0;
        idle_pc4_d = idle_pc4_q;

        case (state_q)
            ST_RUN: begin
                ready_d = 1'b1;
                if (accept) begin
                    if (enc_valid) begin
                        state_d  = ST_TRAP;
                        ready_d  = 1'b0;
                        is_exc_d = 1'b1;
                        flush_d  = 1'b1;
                        rvalid_d = 1'b1;
                        cause_d  = enc_cause;
                        ecode_d  = enc_ecode;
                        esub_d   = enc_esub;
                        epc_d    = commit.commit_pc;
                        case (enc_sel)
                            ADDR_PC:  eaddr_d = commit.commit_pc;
                            ADDR_MEM: eaddr_d = commit.commit_mem_addr;
                            default:  eaddr_d = 32'd0;
                        endcase
                        rpc_d = (enc_ecode == ECODE_TLBR) ? tlbrentry_pa : eentry_va;
                    end else if (commit.commit_ertn) begin
                        state_d   = ST_ERET;
                        ready_d   = 1'b0;
                        is_ertn_d = 1'b1;
                        flush_d   = 1'b1;
                        rvalid_d  = 1'b1;
                        rpc_d     = era_pc;
                    end else if (commit.commit_idle) begin
                        state_d    = ST_IDLE;
                        ready_d    = 1'b0;
                        stall_d    = 1'b1;
                        idle_pc4_d = commit.commit_pc + 32'd4;
                    end
                end
            end

            ST_IDLE: begin
                // Wake on any pending interrupt; only take it if enabled,
                // otherwise just resume after the idle instruction.
                if (int_pend) begin
                    flush_d  = 1'b1;
                    rvalid_d = 1'b1;
                    if (crmd_ie) begin
                        state_d  = ST_TRAP;
                        is_exc_d = 1'b1;
                        cause_d  = CAUSE_INT;
                        ecode_d  = ECODE_INT;
                        epc_d    = idle_pc4_q;
                        rpc_d    = eentry_va;
                    end else begin
                        state_d = ST_RESUME;
                        rpc_d   = idle_pc4_q;
                    end
                end else begin
                    stall_d = 1'b1;
                end
            end

            ST_TRAP, ST_ERET, ST_RESUME: begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
        endcase
    end

    assign commit.commit_ready = ready_q;
    assign is_exception        = is_exc_q;
    assign exception_cause     = cause_q;
    assign ecode               = ecode_q;
    assign esubcode            = esub_q;
    assign exception_pc        = epc_q;
    assign exception_addr      = eaddr_q;
    assign is_ertn             = is_ertn_q;
    assign flush               = flush_q;
    assign redirect_valid      = rvalid_q;
    assign redirect_pc         = rpc_q;
    assign idle_stall          = stall_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed testbench for trap_ctrl. Inputs change on the
// falling edge, outputs are sampled on the following falling edge.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    logic         clk;
    logic         rst;
    logic         crmd_ie;
    logic [11:0]  ecfg_lie;
    logic [11:0]  estat_is;
    logic [31:0]  eentry_va;
    logic [31:0]  tlbrentry_pa;
    logic [31:0]  era_pc;
    logic         is_exception;
    trap_cause_t  exception_cause;
    logic [5:0]   ecode;
    logic [8:0]   esubcode;
    logic [31:0]  exception_pc;
    logic [31:0]  exception_addr;
    logic         is_ertn;
    logic         flush;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         idle_stall;

    int total;
    int bad;

    trap_ctrl_if cif ();

    trap_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .commit          (cif.slave),
        .crmd_ie         (crmd_ie),
        .ecfg_lie        (ecfg_lie),
        .estat_is        (estat_is),
        .eentry_va       (eentry_va),
        .tlbrentry_pa    (tlbrentry_pa),
        .era_pc          (era_pc),
        .is_exception    (is_exception),
        .exception_cause (exception_cause),
        .ecode           (ecode),
        .esubcode        (esubcode),
        .exception_pc    (exception_pc),
        .exception_addr  (exception_addr),
        .is_ertn         (is_ertn),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .idle_stall      (idle_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic present(input logic [31:0] pc, input logic [14:0] excp,
                           input logic [31:0] mem, input logic ertn, input logic idl);
        cif.commit_valid    = 1'b1;
        cif.commit_pc       = pc;
        cif.commit_excp     = excp;
        cif.commit_mem_addr = mem;
        cif.commit_ertn     = ertn;
        cif.commit_idle     = idl;
    endtask

    task automatic clear_commit();
        cif.commit_valid    = 1'b0;
        cif.commit_pc       = 32'd0;
        cif.commit_excp     = 15'd0;
        cif.commit_mem_addr = 32'd0;
        cif.commit_ertn     = 1'b0;
        cif.commit_idle     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_commit();
        crmd_ie = 1'b0; ecfg_lie = 12'd0; estat_is = 12'd0;
        eentry_va = 32'h1C008000; tlbrentry_pa = 32'h0000F000; era_pc = 32'd0;
        repeat (3) @(negedge clk);
        total++; if (cif.commit_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cif.commit_ready); end
        total++; if (is_exception !== 1'b0) begin bad++; $display("FAIL reset_is_exception got=%b want=0", is_exception); end
        total++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b/%b want=0/0", flush, redirect_valid); end
        total++; if (is_ertn !== 1'b0 || idle_stall !== 1'b0) begin bad++; $display("FAIL reset_ertn_stall got=%b/%b want=0/0", is_ertn, idle_stall); end
        rst = 1'b0;
        $display("txn reset: ready=%b", cif.commit_ready);
    endtask

    task automatic test_normal();
        for (int i = 0; i < 3; i++) begin
            present(32'h1C000000 + 32'(i * 4), 15'd0, 32'd0, 1'b0, 1'b0);
            @(negedge clk);
            total++; if (cif.commit_ready !== 1'b1) begin bad++; $display("FAIL normal_ready got=%b want=1", cif.commit_ready); end
            total++; if ({is_exception, is_ertn, flush, redirect_valid} !== 4'b0) begin bad++; $display("FAIL normal_pulses got=%b want=0000", {is_exception, is_ertn, flush, redirect_valid}); end
            $display("txn normal retire pc=%h", 32'h1C000000 + 32'(i * 4));
        end
        clear_commit();
        @(negedge clk);
    endtask

    task automatic test_sys();
        present(32'h1C000100, 15'(1 << EXCP_SYS), 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        clear_commit();
        total++; if (is_exception !== 1'b1) begin bad++; $display("FAIL sys_is_exception got=%b want=1", is_exception); end
        total++; if (ecode !== 6'h0B) begin bad++; $display("FAIL sys_ecode got=%h want=0b", ecode); end
        total++; if (exception_cause !== CAUSE_SYS) begin bad++; $display("FAIL sys_cause got=%0d want=%0d", exception_cause, CAUSE_SYS); end
        total++; if (exception_pc !== 32'h1C000100) begin bad++; $display("FAIL sys_epc got=%h want=1c000100", exception_pc); end
        total++; if (exception_addr !== 32'd0) begin bad++; $display("FAIL sys_badv got=%h want=0", exception_addr); end
        total++; if (redirect_pc !== 32'h1C008000 || redirect_valid !== 1'b1 || flush !== 1'b1) begin bad++; $display("FAIL sys_redirect got=%h/%b/%b want=1c008000/1/1", redirect_pc, redirect_valid, flush); end
        total++; if (cif.commit_ready !== 1'b0) begin bad++; $display("FAIL sys_ready_low got=%b want=0", cif.commit_ready); end
        @(negedge clk);
        total++; if (cif.commit_ready !== 1'b1 || is_exception !== 1'b0) begin bad++; $display("FAIL sys_after got=%b/%b want=1/0", cif.commit_ready, is_exception); end
        $display("txn sys pc=1c000100 ecode=%h redirect=%h", 6'h0B, 32'h1C008000);
    endtask

    task automatic test_ale_pil();
        present(32'h1C000110, 15'((1 << EXCP_ALE) | (1 << EXCP_PIL)), 32'h80000003, 1'b0, 1'b0);
        @(negedge clk);
        clear_commit();
        total++; if (ecode !== 6'h09) begin bad++; $display("FAIL ale_ecode got=%h want=09", ecode); end
        total++; if (exception_addr !== 32'h80000003) begin bad++; $display("FAIL ale_badv got=%h want=80000003", exception_addr); end
        total++; if (esubcode !== 9'd0) begin bad++; $display("FAIL ale_esub got=%h want=0", esubcode); end
        @(negedge clk);
        $display("txn ale|pil mem=80000003");
    endtask

    task automatic test_adem_adef();
        // ADEF beats ADEM; BADV is then the pc.
        present(32'h1C000120, 15'((1 << EXCP_ADEM) | (1 << EXCP_ADEF)), 32'h12345678, 1'b0, 1'b0);
        @(negedge clk);
        clear_commit();
        total++; if (ecode !== 6'h08 || esubcode !== 9'd0) begin bad++; $display("FAIL adef_code got=%h/%h want=08/0", ecode, esubcode); end
        total++; if (exception_addr !== 32'h1C000120) begin bad++; $display("FAIL adef_badv got=%h want=1c000120", exception_addr); end
        @(negedge clk);
        present(32'h1C000124, 15'(1 << EXCP_ADEM), 32'h12345678, 1'b0, 1'b0);
        @(negedge clk);
        clear_commit();
        total++; if (ecode !== 6'h08 || esubcode !== 9'd1) begin bad++; $display("FAIL adem_code got=%h/%h want=08/1", ecode, esubcode); end
        total++; if (exception_addr !== 32'h12345678) begin bad++; $display("FAIL adem_badv got=%h want=12345678", exception_addr); end
        @(negedge clk);
        $display("txn adef then adem");
    endtask

    task automatic test_tlbr();
        present(32'h1C000130, 15'(1 << EXCP_TLBR_M), 32'h00400000, 1'b0, 1'b0);
        @(negedge clk);
        clear_commit();
        total++; if (ecode !== 6'h3F) begin bad++; $display("FAIL tlbr_ecode got=%h want=3f", ecode); end
        total++; if (redirect_pc !== 32'h0000F000) begin bad++; $display("FAIL tlbr_redirect got=%h want=0000f000", redirect_pc); end
        @(negedge clk);
        $display("txn tlbr_m redirect=0000f000");
    endtask

    task automatic test_int_over_ertn();
        crmd_ie = 1'b1; ecfg_lie = 12'h800; estat_is = 12'h800; era_pc = 32'h1C000500;
        present(32'h1C000140, 15'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        clear_commit();
        crmd_ie = 1'b0; ecfg_lie = 12'd0; estat_is = 12'd0;
        total++; if (is_exception !== 1'b1 || exception_cause !== CAUSE_INT) begin bad++; $display("FAIL int_taken got=%b/%0d want=1/%0d", is_exception, exception_cause, CAUSE_INT); end
        total++; if (ecode !== 6'h00 || exception_pc !== 32'h1C000140) begin bad++; $display("FAIL int_fields got=%h/%h want=00/1c000140", ecode, exception_pc); end
        total++; if (is_ertn !== 1'b0 || redirect_pc !== 32'h1C008000) begin bad++; $display("FAIL int_ertn_suppressed got=%b/%h want=0/1c008000", is_ertn, redirect_pc); end
        @(negedge clk);
        $display("txn interrupt over ertn");
    endtask

    task automatic test_ertn();
        era_pc = 32'h1C000500;
        present(32'h1C000150, 15'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        clear_commit();
        era_pc = 32'hDEADBEEC;
        total++; if (is_ertn !== 1'b1 || is_exception !== 1'b0) begin bad++; $display("FAIL ertn_pulse got=%b/%b want=1/0", is_ertn, is_exception); end
        total++; if (redirect_pc !== 32'h1C000500 || flush !== 1'b1) begin bad++; $display("FAIL ertn_redirect got=%h/%b want=1c000500/1", redirect_pc, flush); end
        @(negedge clk);
        total++; if (is_ertn !== 1'b0 || cif.commit_ready !== 1'b1) begin bad++; $display("FAIL ertn_after got=%b/%b want=0/1", is_ertn, cif.commit_ready); end
        $display("txn ertn era=1c000500");
    endtask

    task automatic test_int_no_valid();
        crmd_ie = 1'b1; ecfg_lie = 12'h001; estat_is = 12'h001;
        @(negedge clk);
        total++; if (is_exception !== 1'b0) begin bad++; $display("FAIL int_idle_bus got=%b want=0", is_exception); end
        present(32'h1C000300, 15'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        clear_commit();
        crmd_ie = 1'b0; ecfg_lie = 12'd0; estat_is = 12'd0;
        total++; if (is_exception !== 1'b1 || exception_pc !== 32'h1C000300) begin bad++; $display("FAIL int_on_commit got=%b/%h want=1/1c000300", is_exception, exception_pc); end
        @(negedge clk);
        $display("txn interrupt waits for commit pc=1c000300");
    endtask

    task automatic test_idle(input logic ie, input logic [31:0] pc, input logic [31:0] pc4);
        crmd_ie = ie; ecfg_lie = 12'h004; estat_is = 12'h000;
        present(pc, 15'd0, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        clear_commit();
        for (int i = 0; i < 5; i++) begin
            total++; if (idle_stall !== 1'b1 || cif.commit_ready !== 1'b0) begin bad++; $display("FAIL idle_wait%0d got=%b/%b want=1/0", i, idle_stall, cif.commit_ready); end
            @(negedge clk);
        end
        estat_is = 12'h004;
        @(negedge clk);
        estat_is = 12'h000;
        total++; if (flush !== 1'b1 || redirect_valid !== 1'b1 || idle_stall !== 1'b0) begin bad++; $display("FAIL idle_wake got=%b/%b/%b want=1/1/0", flush, redirect_valid, idle_stall); end
        if (ie) begin
            total++; if (is_exception !== 1'b1 || exception_pc !== pc4 || ecode !== 6'h00) begin bad++; $display("FAIL idle_trap got=%b/%h/%h want=1/%h/00", is_exception, exception_pc, ecode, pc4); end
            total++; if (redirect_pc !== 32'h1C008000) begin bad++; $display("FAIL idle_trap_redirect got=%h want=1c008000", redirect_pc); end
        end else begin
            total++; if (is_exception !== 1'b0 || redirect_pc !== pc4) begin bad++; $display("FAIL idle_resume got=%b/%h want=0/%h", is_exception, redirect_pc, pc4); end
        end
        @(negedge clk);
        crmd_ie = 1'b0; ecfg_lie = 12'd0;
        total++; if (cif.commit_ready !== 1'b1 || flush !== 1'b0) begin bad++; $display("FAIL idle_after got=%b/%b want=1/0", cif.commit_ready, flush); end
        $display("txn idle pc=%h ie=%b resume=%h", pc, ie, pc4);
    endtask

    task automatic test_back_to_back();
        present(32'h1C000400, 15'(1 << EXCP_BRK), 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (is_exception !== 1'b1 || ecode !== 6'h0C) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/0c", is_exception, ecode); end
        @(negedge clk);
        total++; if (is_exception !== 1'b0 || cif.commit_ready !== 1'b1) begin bad++; $display("FAIL b2b_gap got=%b/%b want=0/1", is_exception, cif.commit_ready); end
        @(negedge clk);
        clear_commit();
        total++; if (is_exception !== 1'b1 || ecode !== 6'h0C) begin bad++; $display("FAIL b2b_second got=%b/%h want=1/0c", is_exception, ecode); end
        @(negedge clk);
        $display("txn back-to-back brk");
    endtask

    task automatic test_reset_mid();
        present(32'h1C000600, 15'(1 << EXCP_INE), 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        clear_commit();
        total++; if (is_exception !== 1'b1 || ecode !== 6'h0D) begin bad++; $display("FAIL rst_trap_pre got=%b/%h want=1/0d", is_exception, ecode); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({is_exception, flush, redirect_valid, is_ertn} !== 4'b0 || exception_pc !== 32'd0) begin bad++; $display("FAIL rst_trap_outputs got=%b/%h want=0000/0", {is_exception, flush, redirect_valid, is_ertn}, exception_pc); end
        total++; if (cif.commit_ready !== 1'b1) begin bad++; $display("FAIL rst_trap_ready got=%b want=1", cif.commit_ready); end
        @(negedge clk);
        total++; if (is_exception !== 1'b0) begin bad++; $display("FAIL rst_trap_replay got=%b want=0", is_exception); end
        ecfg_lie = 12'h004;
        present(32'h1C000700, 15'd0, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        clear_commit();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ecfg_lie = 12'd0;
        total++; if (idle_stall !== 1'b0 || cif.commit_ready !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b/%b want=0/1", idle_stall, cif.commit_ready); end
        $display("txn reset during trap and idle");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_normal();
        test_sys();
        test_ale_pil();
        test_adem_adef();
        test_tlbr();
        test_int_over_ertn();
        test_ertn();
        test_int_no_valid();
        test_idle(1'b0, 32'h1C000200, 32'h1C000204);
        test_idle(1'b1, 32'h1C000200, 32'h1C000204);
        test_idle(1'b0, 32'hFFFFFFFC, 32'h00000000);
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Commit-boundary trap sequencer between the commit stage and the CSR file. It arbitrates among pending interrupts, per-instruction exceptions, `ertn` and `idle`, and selects one event per accepted commit. For that event it drives the CSR exception update pulse (ecode, esubcode, pc, bad address) and the front-end flush/redirect. It also holds the pipeline in a low-power wait after `idle` until an interrupt arrives.

## Interface
- Parameters: none.
- `clk`  in  1  clock
- `rst`  in  1  reset rst, synchronous, active-high; clock clk
- `commit_valid`  in  1  commit stage presents one instruction
- `commit_ready`  out  1  trap_ctrl accepts the instruction; transfer = valid & ready
- `commit_pc`  in  32  pc of the presented instruction
- `commit_excp`  in  15  exception flags, bit index = priority (0 highest): 0 ADEF, 1 TLBR_F, 2 PIF, 3 PPI_F, 4 IPE, 5 INE, 6 SYS, 7 BRK, 8 ALE, 9 ADEM, 10 TLBR_M, 11 PIL, 12 PIS, 13 PME, 14 PPI_M
- `commit_mem_addr`  in  32  data virtual address (memory-side exceptions)
- `commit_ertn`  in  1  instruction is `ertn`
- `commit_idle`  in  1  instruction is `idle`
- `crmd_ie`  in  1  global interrupt enable
- `ecfg_lie`  in  12  local interrupt enables {ti/ipi, hwi, swi}
- `estat_is`  in  12  interrupt status, same layout as `ecfg_lie`
- `eentry_va`  in  32  general exception entry
- `tlbrentry_pa`  in  32  TLB-refill entry
- `era_pc`  in  32  return address
- `is_exception`  out  1  one-cycle CSR exception update
- `exception_cause`  out  5  `trap_cause_t` enum
- `ecode`  out  6  ESTAT.Ecode
- `esubcode`  out  9  ESTAT.EsubCode
- `exception_pc`  out  32  pc written to ERA by the CSR file
- `exception_addr`  out  32  value written to BADV
- `is_ertn`  out  1  one-cycle CSR restore pulse
- `flush`  out  1  flush all stages younger than commit
- `redirect_valid`  out  1  fetch redirect strobe
- `redirect_pc`  out  32  redirect target
- `idle_stall`  out  1  fetch/commit frozen by `idle`

## Operation
- `int_pend = |(ecfg_lie & estat_is)`. `int_take = int_pend & crmd_ie`.
- Precedence on an accepted commit: interrupt > lowest set `commit_excp` bit > `ertn` > `idle` > normal retire.
- Interrupt events use `commit_pc`; the instruction does not retire.
- Cause decode:
  - INT 0x00; PIL 0x01; PIS 0x02; PIF 0x03; PME 0x04; PPI 0x07.
  - ADEF 0x08/sub 0; ADEM 0x08/sub 1.
  - ALE 0x09; SYS 0x0B; BRK 0x0C; INE 0x0D; IPE 0x0E; TLBR 0x3F.
  - esubcode is 0 unless stated.
- `exception_addr`: `commit_pc` for ADEF, TLBR_F, PIF, PPI_F; `commit_mem_addr` for ALE, ADEM, TLBR_M, PIL, PIS, PME, PPI_M; 0 otherwise.
- Redirect target: `tlbrentry_pa` for TLBR; `eentry_va` for all other exceptions and interrupts; `era_pc` for `ertn`.
- States:
  - RUN: `commit_ready`=1.
    - Accepted exception or interrupt → TRAP.
    - Accepted `ertn` → ERET.
    - Accepted `idle` → IDLE.
    - Otherwise stay in RUN.
  - TRAP: one cycle. `is_exception`, `flush`, `redirect_valid`=1 with the registered fields; `commit_ready`=0. → RUN.
  - ERET: one cycle. `is_ertn`, `flush`, `redirect_valid`=1, `redirect_pc`=registered `era_pc`; `commit_ready`=0. → RUN.
  - IDLE: `idle_stall`=1, `commit_ready`=0.
    - When `int_pend`: if `crmd_ie` → TRAP with cause INT and `exception_pc` = idle pc + 4; else → RESUME.
  - RESUME: one cycle. `flush`, `redirect_valid`=1, `redirect_pc` = idle pc + 4. → RUN.
- Idle pc + 4 uses 32-bit wrap-around; 0xFFFFFFFC+4 = 0.

## Timing
- All outputs are registered. The event is decided in the accept cycle, and outputs are asserted exactly the following cycle for one cycle.
- The CSR file samples `is_exception`/`is_ertn` on the edge that ends the TRAP/ERET cycle. CSR inputs are sampled at accept, not later.
- Back-to-back: `commit_ready` returns to 1 the cycle after TRAP/ERET/RESUME. Maximum trap rate is one per 2 cycles.
- `int_pend` rising while `commit_valid`=0 is not taken until the next accepted commit.
- Reset (any state, including mid-TRAP or IDLE): state RUN; all outputs 0 except `commit_ready`=1; pulses are dropped, not replayed.

## Structure
- `pipeline_types` gains:
  - `trap_cause_t` (5-bit enum).
  - `EXCP_*` bit-index localparams.
  - `ECODE_*`/`ESUB_*` constants.
  - `trap_state_t`.
- One sub-module, `excp_prio_enc`: 15-bit flags + interrupt → valid, cause, ecode, esubcode, addr_sel. Purely combinational.

## Test plan
- Normal retire, RUN: `commit_excp`=0, no interrupt → no pulses; `commit_ready` stays 1.
- SYS at pc 0x1C000100, `eentry_va`=0x1C008000 → next cycle:
  - `is_exception`=1, ecode 0x0B, `exception_pc` 0x1C000100.
  - `redirect_pc` 0x1C008000; `commit_ready`=0 for one cycle.
- Flags ALE|PIL with `commit_mem_addr`=0x80000003 → ecode 0x09 (ALE wins), `exception_addr` 0x80000003.
- TLBR_M with `tlbrentry_pa`=0x0000F000 → ecode 0x3F, redirect 0x0000F000.
- Interrupt with `crmd_ie`=1, `ecfg_lie`[11]=`estat_is`[11]=1, while an `ertn` commits → INT taken, ecode 0; `ertn` suppressed.
- `idle` at 0x1C000200 with ie=0; after 5 cycles raise `estat_is`[2] with `ecfg_lie`[2]=1:
  - `idle_stall`=1 throughout the wait.
  - Then RESUME with `redirect_pc` 0x1C000204.
  - Repeat with ie=1 → TRAP, `exception_pc` 0x1C000204.
- Assert `rst` during TRAP → outputs zero next cycle; state RUN.
